hazard_sched_ctrl: RTL and testbench
====================================

Name: hazard_sched_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage CPU.
- Drives the IF/ID register's stall_ctr/flush_ctr and the PC write enable.
- Inserts ID/EX bubbles and freezes the back end on data-memory wait.
- Sequences multi-cycle load-use stalls and branch flushes with an FSM; keeps saturating stall/flush performance counters.

Parameters:
REG_ADDR, 5, register specifier width
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3; 2 for no-forwarding builds)
FLUSH_DEPTH, 1, cycles of front-end flush per taken branch (1..3)
CNT_WIDTH, 16, width of performance counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
ifid_rs  input  REG_ADDR  rs field of instruction held in IF/ID
ifid_rt  input  REG_ADDR  rt field of instruction held in IF/ID
ifid_uses_rt  input  1  IF/ID instruction reads rt
idex_mem_read  input  1  instruction in ID/EX is a load
idex_rt  input  REG_ADDR  destination of load in ID/EX
branch_taken  input  1  branch/jump resolved taken in EX this cycle
imem_wait  input  1  instruction memory output not valid this cycle
dmem_wait  input  1  data memory not ready; back end must hold
cnt_clr  input  1  synchronous clear of both counters
pc_write_en  output  1  PC may update
ifid_stall  output  1  to IF/ID stall_ctr
ifid_flush  output  1  to IF/ID flush_ctr
idex_flush  output  1  load NOP into ID/EX
pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB
state_o  output  2  current FSM state encoding
stall_cycles  output  CNT_WIDTH  cycles with pc_write_en=0
flush_events  output  CNT_WIDTH  accepted taken branches

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (rst=1, asynchronous):
  - state=RUN, ret_state=RUN, lu_cnt=0, fl_cnt=0, both counters 0.
  - Outputs forced while rst=1: pc_write_en=0, ifid_flush=1, idex_flush=1, ifid_stall=0, pipe_freeze=0, state_o=0.
  - Reset mid-operation abandons any stall/flush immediately.
- Load-use detection: load_use = idex_mem_read & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Control outputs are combinational (Mealy) from state and inputs. State and counters update on the clk rising edge.
- Default outputs: pc_write_en=1, all others 0.
- Global priority in every state: dmem_wait > branch_taken > load_use > imem_wait.
- States (state_o): RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3.
- RUN:
  - dmem_wait: pc_write_en=0, ifid_stall=1, pipe_freeze=1; ret_state<=RUN; go MEM_WAIT.
  - else branch_taken: ifid_flush=1, idex_flush=1, pc_write_en=1. If FLUSH_DEPTH>1, fl_cnt<=FLUSH_DEPTH-1 and go BR_FLUSH.
  - else load_use: pc_write_en=0, ifid_stall=1, idex_flush=1. If LU_STALL_CYCLES>1, lu_cnt<=LU_STALL_CYCLES-1 and go LU_STALL.
  - else imem_wait: pc_write_en=0, ifid_flush=1 (NOP into IF/ID); stay in RUN.
- LU_STALL:
  - Outputs as the RUN load-use case regardless of load_use; lu_cnt decrements; lu_cnt==1 -> RUN next.
  - branch_taken: stall abandoned, branch handling as in RUN.
- BR_FLUSH:
  - ifid_flush=1, idex_flush=1, pc_write_en=1; fl_cnt decrements; fl_cnt==1 -> RUN next.
  - A new branch_taken reloads fl_cnt<=FLUSH_DEPTH-1 and counts as a new event.
- MEM_WAIT:
  - pc_write_en=0, ifid_stall=1, pipe_freeze=1, no flushes.
  - Hold while dmem_wait=1. On dmem_wait=0, return to ret_state with lu_cnt/fl_cnt unchanged; outputs that cycle are those of ret_state.
- dmem_wait in LU_STALL or BR_FLUSH: same freeze outputs; ret_state<=current; lu_cnt/fl_cnt frozen; go MEM_WAIT.
- ifid_stall and ifid_flush are never both 1.
- Counters:
  - stall_cycles +1 each non-reset cycle with pc_write_en=0.
  - flush_events +1 per cycle where branch_taken is acted on (not when masked by dmem_wait).
  - Both saturate at all-ones.
  - cnt_clr has priority over increment: counter <= 0 that edge.

Test Plan:
- Reset then idle inputs -> pc_write_en=1, all other controls 0, state_o=0, counters 0; rst pulsed mid-LU_STALL -> state_o=0 immediately, counters 0.
- idex_mem_read=1, idex_rt=5, ifid_rs=5, LU_STALL_CYCLES=2 -> two cycles of pc_write_en=0/ifid_stall=1/idex_flush=1, then RUN, stall_cycles=2. Repeat with idex_rt=0 -> no stall.
- branch_taken 1 cycle, FLUSH_DEPTH=3 -> ifid_flush=idex_flush=1 for 3 cycles with pc_write_en=1, flush_events=1; second branch in cycle 2 -> 3 more flush cycles from it, flush_events=2.
- dmem_wait raised in BR_FLUSH with fl_cnt=1 for 4 cycles -> 4 cycles pipe_freeze=1/ifid_stall=1/no flush, state_o=3; then 1 remaining flush cycle, then RUN.
- dmem_wait+branch_taken+load_use in same RUN cycle -> freeze only, flush_events unchanged; imem_wait alone -> pc_write_en=0, ifid_flush=1, ifid_stall=0.
- CNT_WIDTH=4, hold imem_wait 20 cycles -> stall_cycles saturates at 15; cnt_clr with imem_wait=1 -> 0 next edge.

Source files
------------

// File: rtl/hazard_sched_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: load-use stalls, branch flushes,
// data-memory freezes and saturating stall/flush performance counters.
module hazard_sched_ctrl #(
  parameter int REG_ADDR        = 5,
  parameter int LU_STALL_CYCLES = 1,
  parameter int FLUSH_DEPTH     = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_ADDR-1:0]  ifid_rs,
  input  logic [REG_ADDR-1:0]  ifid_rt,
  input  logic                 ifid_uses_rt,
  input  logic                 idex_mem_read,
  input  logic [REG_ADDR-1:0]  idex_rt,
  input  logic                 branch_taken,
  input  logic                 imem_wait,
  input  logic                 dmem_wait,
  input  logic                 cnt_clr,
  output logic                 pc_write_en,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 pipe_freeze,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYCLES - 1);
  localparam logic [1:0] FL_RELOAD = 2'(FLUSH_DEPTH - 1);

  state_t     state, ret_state, state_nx, ret_nx, eff;
  logic [1:0] lu_cnt, fl_cnt, lu_nx, fl_nx;
  logic       load_use, br_acted;

  assign load_use = idex_mem_read && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign br_acted = branch_taken && !dmem_wait;

  always_comb begin
    // On the release cycle of a memory wait, behave exactly as the saved state.
    eff         = (state == MEM_WAIT && !dmem_wait) ? ret_state : state;
    pc_write_en = 1'b1;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pipe_freeze = 1'b0;
    state_nx    = eff;
    ret_nx      = ret_state;
    lu_nx       = lu_cnt;
    fl_nx       = fl_cnt;
    if (dmem_wait) begin
      pc_write_en = 1'b0;
      ifid_stall  = 1'b1;
      pipe_freeze = 1'b1;
      state_nx    = MEM_WAIT;
      if (state != MEM_WAIT) ret_nx = state;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      lu_nx      = 2'd0;
      if (FLUSH_DEPTH > 1) begin
        fl_nx    = FL_RELOAD;
        state_nx = BR_FLUSH;
      end else begin
        state_nx = RUN;
      end
    end else begin
      case (eff)
        LU_STALL: begin
          pc_write_en = 1'b0;
          ifid_stall  = 1'b1;
          idex_flush  = 1'b1;
          lu_nx       = lu_cnt - 2'd1;
          if (lu_cnt <= 2'd1) state_nx = RUN;
        end
        BR_FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          fl_nx      = fl_cnt - 2'd1;
          if (fl_cnt <= 2'd1) state_nx = RUN;
        end
        default: begin
          state_nx = RUN;
          if (load_use) begin
            pc_write_en = 1'b0;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              lu_nx    = LU_RELOAD;
              state_nx = LU_STALL;
            end
          end else if (imem_wait) begin
            pc_write_en = 1'b0;
            ifid_flush  = 1'b1;
          end
        end
      endcase
    end
    if (rst) begin
      pc_write_en = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      pipe_freeze = 1'b0;
    end
  end

  assign state_o = rst ? 2'd0 : state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      ret_state    <= RUN;
      lu_cnt       <= 2'd0;
      fl_cnt       <= 2'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state     <= state_nx;
      ret_state <= ret_nx;
      lu_cnt    <= lu_nx;
      fl_cnt    <= fl_nx;
      if (cnt_clr)
        stall_cycles <= '0;
      else if (!pc_write_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (cnt_clr)
        flush_events <= '0;
      else if (br_acted && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl (LU_STALL_CYCLES=2, FLUSH_DEPTH=3, CNT_WIDTH=4).
module tb_hazard_sched_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs = '0, ifid_rt = '0, idex_rt = '0;
  logic       ifid_uses_rt = 0, idex_mem_read = 0, branch_taken = 0;
  logic       imem_wait = 0, dmem_wait = 0, cnt_clr = 0;
  logic       pc_write_en, ifid_stall, ifid_flush, idex_flush, pipe_freeze;
  logic [1:0] state_o;
  logic [3:0] stall_cycles, flush_events;
  int n_chk = 0, n_fail = 0;

  hazard_sched_ctrl #(.REG_ADDR(5), .LU_STALL_CYCLES(2), .FLUSH_DEPTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait), .cnt_clr(cnt_clr),
    .pc_write_en(pc_write_en), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .pipe_freeze(pipe_freeze), .state_o(state_o),
    .stall_cycles(stall_cycles), .flush_events(flush_events));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control bundle: {pc_write_en, ifid_stall, ifid_flush, idex_flush, pipe_freeze, state_o}
  task automatic ctl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, pc_write_en, ifid_stall, ifid_flush, idex_flush, pipe_freeze, state_o}, {25'd0, exp});
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  localparam logic [6:0] IDLE0 = 7'b10000_00;
  localparam logic [6:0] RSTO  = 7'b00110_00;

  initial begin
    #3;
    ctl("reset_outputs", RSTO);
    chk("reset_stall_cnt", stall_cycles, 0);
    chk("reset_flush_cnt", flush_events, 0);
    tick; tick;
    rst = 0; #2;
    ctl("idle", IDLE0);
    tick;

    // load-use via rs, two stall cycles
    idex_mem_read = 1; idex_rt = 5; ifid_rs = 5; #2;
    ctl("lu_c0", 7'b01010_00);
    tick;
    idex_mem_read = 0; #2;
    ctl("lu_c1", 7'b01010_01);
    tick; #1;
    ctl("lu_done", IDLE0);
    chk("lu_stall_cnt", stall_cycles, 2);
    idex_mem_read = 1; idex_rt = 0; ifid_rs = 0; #1;
    ctl("lu_rt0_none", IDLE0);
    tick;
    idex_mem_read = 0; #1;
    chk("lu_rt0_cnt", stall_cycles, 2);

    // branch, then second branch while flushing
    branch_taken = 1; #1;
    ctl("br_c0", 7'b10110_00);
    tick;
    branch_taken = 0; #1;
    ctl("br_c1", 7'b10110_10);
    chk("br_cnt1", flush_events, 1);
    tick;
    branch_taken = 1; #1;
    ctl("br2_c0", 7'b10110_10);
    tick;
    branch_taken = 0; #1;
    ctl("br2_c1", 7'b10110_10);
    chk("br_cnt2", flush_events, 2);
    tick; #1;
    ctl("br2_c2", 7'b10110_10);
    tick; #1;
    ctl("br2_done", IDLE0);

    // dmem_wait hits the last flush cycle
    branch_taken = 1; #1;
    ctl("brw_c0", 7'b10110_00);
    tick;
    branch_taken = 0; #1;
    ctl("brw_c1", 7'b10110_10);
    tick;
    dmem_wait = 1; #1;
    ctl("brw_frz0", 7'b01001_10);
    for (int i = 1; i < 4; i++) begin
      tick; #1;
      ctl("brw_frz", 7'b01001_11);
    end
    tick;
    dmem_wait = 0; #1;
    ctl("brw_resume", 7'b10110_11);
    tick; #1;
    ctl("brw_done", IDLE0);
    chk("brw_stall_cnt", stall_cycles, 6);
    chk("brw_flush_cnt", flush_events, 3);

    // dmem_wait masks branch and load-use
    dmem_wait = 1; branch_taken = 1; idex_mem_read = 1; idex_rt = 5; ifid_rs = 5; #1;
    ctl("prio_frz", 7'b01001_00);
    tick;
    dmem_wait = 0; branch_taken = 0; idex_mem_read = 0; #1;
    ctl("prio_release", 7'b10000_11);
    chk("prio_flush_cnt", flush_events, 3);
    tick; #1;
    ctl("prio_done", IDLE0);
    chk("prio_stall_cnt", stall_cycles, 7);

    // load-use through rt depends on ifid_uses_rt
    ifid_rs = 0; idex_mem_read = 1; idex_rt = 7; ifid_rt = 7; ifid_uses_rt = 0; #1;
    ctl("rt_unused", IDLE0);
    ifid_uses_rt = 1; #1;
    ctl("rt_used", 7'b01010_00);
    tick;
    idex_mem_read = 0; ifid_uses_rt = 0; #1;
    ctl("rt_used_c1", 7'b01010_01);
    tick;

    // imem_wait, saturation, clear
    imem_wait = 1; #1;
    ctl("imem", 7'b00100_00);
    for (int i = 0; i < 20; i++) tick;
    chk("sat_stall", stall_cycles, 15);
    cnt_clr = 1;
    tick;
    cnt_clr = 0; #1;
    chk("clr_stall", stall_cycles, 0);
    chk("clr_flush", flush_events, 0);
    tick;
    chk("post_clr_stall", stall_cycles, 1);

    // reset in the middle of a load-use stall
    imem_wait = 0; idex_mem_read = 1; idex_rt = 5; ifid_rs = 5;
    tick;
    idex_mem_read = 0; #1;
    ctl("pre_rst_lu", 7'b01010_01);
    rst = 1; #1;
    ctl("mid_rst", RSTO);
    chk("mid_rst_stall_cnt", stall_cycles, 0);
    tick;
    rst = 0; #1;
    ctl("post_rst_idle", IDLE0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
